// File: rtl/sha256_round_unit.sv
// SHA-256 compression rounds, H accumulation and serial digest output.
// Define SHA256_ROUND_K_ROM_EN to source K[t] from an internal ROM instead of in1.
module sha256_round_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              done,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] out0,
   output logic              out_valid,
   input  logic [7:0]        delay0,
   input  logic              init0
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      ROUND = 3'd2,
      ADD   = 3'd3,
      OUT   = 3'd4
   } state_t;

   localparam logic [DATA_W-1:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   state_t state, state_nxt;

   logic [DATA_W-1:0] h_r [8];
   logic [DATA_W-1:0] wv  [8];
   logic [5:0]        rnd;
   logic [7:0]        dly;
   logic [2:0]        oidx;

   logic [DATA_W-1:0] k_t;
   logic [DATA_W-1:0] s0, s1, ch, maj, t1, t2;

   function automatic logic [DATA_W-1:0] rotr(
      input logic [DATA_W-1:0] x,
      input int                n
   );
      return (x >> n) | (x << (DATA_W - n));
   endfunction

`ifdef SHA256_ROUND_K_ROM_EN
   logic [DATA_W-1:0] k_rom;
   logic [DATA_W-1:0] unused_in1;

   assign unused_in1 = in1;

   always_comb begin
      k_rom = '0;
      case (rnd)
         6'd0:  k_rom = 32'h428a2f98;
         6'd1:  k_rom = 32'h71374491;
         6'd2:  k_rom = 32'hb5c0fbcf;
         6'd3:  k_rom = 32'he9b5dba5;
         6'd4:  k_rom = 32'h3956c25b;
         6'd5:  k_rom = 32'h59f111f1;
         6'd6:  k_rom = 32'h923f82a4;
         6'd7:  k_rom = 32'hab1c5ed5;
         6'd8:  k_rom = 32'hd807aa98;
         6'd9:  k_rom = 32'h12835b01;
         6'd10: k_rom = 32'h243185be;
         6'd11: k_rom = 32'h550c7dc3;
         6'd12: k_rom = 32'h72be5d74;
         6'd13: k_rom = 32'h80deb1fe;
         6'd14: k_rom = 32'h9bdc06a7;
         6'd15: k_rom = 32'hc19bf174;
         6'd16: k_rom = 32'he49b69c1;
         6'd17: k_rom = 32'hefbe4786;
         6'd18: k_rom = 32'h0fc19dc6;
         6'd19: k_rom = 32'h240ca1cc;
         6'd20: k_rom = 32'h2de92c6f;
         6'd21: k_rom = 32'h4a7484aa;
         6'd22: k_rom = 32'h5cb0a9dc;
         6'd23: k_rom = 32'h76f988da;
         6'd24: k_rom = 32'h983e5152;
         6'd25: k_rom = 32'ha831c66d;
         6'd26: k_rom = 32'hb00327c8;
         6'd27: k_rom = 32'hbf597fc7;
         6'd28: k_rom = 32'hc6e00bf3;
         6'd29: k_rom = 32'hd5a79147;
         6'd30: k_rom = 32'h06ca6351;
         6'd31: k_rom = 32'h14292967;
         6'd32: k_rom = 32'h27b70a85;
         6'd33: k_rom = 32'h2e1b2138;
         6'd34: k_rom = 32'h4d2c6dfc;
         6'd35: k_rom = 32'h53380d13;
         6'd36: k_rom = 32'h650a7354;
         6'd37: k_rom = 32'h766a0abb;
         6'd38: k_rom = 32'h81c2c92e;
         6'd39: k_rom = 32'h92722c85;
         6'd40: k_rom = 32'ha2bfe8a1;
         6'd41: k_rom = 32'ha81a664b;
         6'd42: k_rom = 32'hc24b8b70;
         6'd43: k_rom = 32'hc76c51a3;
         6'd44: k_rom = 32'hd192e819;
         6'd45: k_rom = 32'hd6990624;
         6'd46: k_rom = 32'hf40e3585;
         6'd47: k_rom = 32'h106aa070;
         6'd48: k_rom = 32'h19a4c116;
         6'd49: k_rom = 32'h1e376c08;
         6'd50: k_rom = 32'h2748774c;
         6'd51: k_rom = 32'h34b0bcb5;
         6'd52: k_rom = 32'h391c0cb3;
         6'd53: k_rom = 32'h4ed8aa4a;
         6'd54: k_rom = 32'h5b9cca4f;
         6'd55: k_rom = 32'h682e6ff3;
         6'd56: k_rom = 32'h748f82ee;
         6'd57: k_rom = 32'h78a5636f;
         6'd58: k_rom = 32'h84c87814;
         6'd59: k_rom = 32'h8cc70208;
         6'd60: k_rom = 32'h90befffa;
         6'd61: k_rom = 32'ha4506ceb;
         6'd62: k_rom = 32'hbef9a3f7;
         6'd63: k_rom = 32'hc67178f2;
      endcase
   end

   assign k_t = k_rom;
`else
   assign k_t = in1;
`endif

   // wv[0..7] hold the working variables a..h
   always_comb begin
      s0  = rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22);
      s1  = rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25);
      ch  = (wv[4] & wv[5]) ^ (~wv[4] & wv[6]);
      maj = (wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]);
      t1  = wv[7] + s1 + ch + k_t + in0;
      t2  = s0 + maj;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (run) begin
         state_nxt = (delay0 != 8'd0) ? WAIT : ROUND;
      end else begin
         unique case (state)
            IDLE:  state_nxt = IDLE;
            WAIT:  if (dly == 8'd1) state_nxt = ROUND;
            ROUND: if (rnd == 6'd63) state_nxt = ADD;
            ADD:   state_nxt = OUT;
            OUT:   if (oidx == 3'd7) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign done = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            h_r[i] <= IV[i];
            wv[i]  <= '0;
         end
         rnd       <= '0;
         dly       <= '0;
         oidx      <= '0;
         out0      <= '0;
         out_valid <= 1'b0;
      end else if (run) begin
         // a run always wins: any block in flight is dropped
         for (int i = 0; i < 8; i++) begin
            if (init0) begin
               h_r[i] <= IV[i];
               wv[i]  <= IV[i];
            end else begin
               wv[i]  <= h_r[i];
            end
         end
         rnd       <= '0;
         dly       <= delay0;
         oidx      <= '0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               out_valid <= 1'b0;
            end
            WAIT: begin
               dly <= dly - 8'd1;
            end
            ROUND: begin
               wv[7] <= wv[6];
               wv[6] <= wv[5];
               wv[5] <= wv[4];
               wv[4] <= wv[3] + t1;
               wv[3] <= wv[2];
               wv[2] <= wv[1];
               wv[1] <= wv[0];
               wv[0] <= t1 + t2;
               rnd   <= rnd + 6'd1;
            end
            ADD: begin
               for (int i = 0; i < 8; i++)
                  h_r[i] <= h_r[i] + wv[i];
               oidx <= '0;
            end
            OUT: begin
               out0      <= h_r[oidx];
               out_valid <= 1'b1;
               oidx      <= oidx + 3'd1;
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_round_unit.sv
// Directed-vector bench for sha256_round_unit using known SHA-256 digests.
// The message schedule is expanded here, standing in for the upstream unit.
module tb_sha256_round_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        done;
   logic [31:0] in0 = '0;
   logic [31:0] in1 = '0;
   logic [31:0] out0;
   logic        out_valid;
   logic [7:0]  delay0 = '0;
   logic        init0 = 1'b0;

   int nchk = 0;
   int nerr = 0;

   logic [31:0] m [16];
   logic [31:0] w [64];
   logic [31:0] ktab [64];

   localparam logic [255:0] DG_ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DG_EMPTY =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] DG_TWO =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   sha256_round_unit #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .done      (done),
      .in0       (in0),
      .in1       (in1),
      .out0      (out0),
      .out_valid (out_valid),
      .delay0    (delay0),
      .init0     (init0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic build_w();
      for (int t = 0; t < 16; t++) w[t] = m[t];
      for (int t = 16; t < 64; t++)
         w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10))
              + w[t-7]
              + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3))
              + w[t-16];
   endtask

   task automatic drive_k(input int t);
`ifdef SHA256_ROUND_K_ROM_EN
      in1 = $urandom();
      if (t < 0) in1 = '0;
`else
      in1 = ktab[t];
`endif
   endtask

   task automatic set_abc();
      m = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 32'h00000018};
   endtask

   task automatic set_empty();
      m = '{32'h80000000, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0};
   endtask

   task automatic set_two_a();
      m = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   endtask

   task automatic set_two_b();
      m = '{0, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 32'h000001c0};
   endtask

   // Runs from a negedge; returns at a negedge after only n rounds.
   task automatic partial(input bit init, input int n, input string tag);
      int nv;
      nv = 0;
      build_w();
      run = 1'b1; init0 = init; delay0 = 8'd0;
      @(negedge clk);
      run = 1'b0;
      for (int t = 0; t < n; t++) begin
         in0 = w[t];
         drive_k(t);
         nv += int'(out_valid);
         @(negedge clk);
      end
      check({tag, "_nv"}, nv, 0);
   endtask

   // mode: 0 ignore digest, 1 must equal exp, 2 must differ from exp
   task automatic do_block(input bit init, input int d,
                           input logic [255:0] exp, input int mode,
                           input string tag);
      int nv;
      bit diff;
      logic [31:0] hold;
      logic [31:0] ew;
      nv = 0;
      diff = 1'b0;
      build_w();
      run = 1'b1; init0 = init; delay0 = d[7:0];
      @(negedge clk);
      run = 1'b0;
      check({tag, "_busy"}, {31'b0, done}, 0);
      hold = out0;
      for (int i = 0; i < d; i++) begin
         check({tag, "_wait"}, {31'b0, out_valid}, 0);
         check({tag, "_hold"}, out0, hold);
         in0 = $urandom();
         in1 = $urandom();
         @(negedge clk);
      end
      for (int t = 0; t < 64; t++) begin
         in0 = w[t];
         drive_k(t);
         nv += int'(out_valid);
         @(negedge clk);
      end
      in0 = $urandom();
      in1 = $urandom();
      nv += int'(out_valid);
      @(negedge clk);
      check({tag, "_add"}, {31'b0, out_valid}, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         nv += int'(out_valid);
         ew = exp[255 - 32*i -: 32];
         check({tag, "_v"}, {31'b0, out_valid}, 1);
         if (mode == 1) check($sformatf("%s_w%0d", tag, i), out0, ew);
         if (out0 !== ew) diff = 1'b1;
      end
      @(negedge clk);
      nv += int'(out_valid);
      check({tag, "_vend"}, {31'b0, out_valid}, 0);
      check({tag, "_done"}, {31'b0, done}, 1);
      if (mode == 1) check({tag, "_o7"}, out0, exp[31:0]);
      check({tag, "_nv"}, nv, 8);
      if (mode == 2) check({tag, "_diff"}, {31'b0, diff}, 1);
   endtask

   initial begin
      ktab = '{
         32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
         32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
         32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
         32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
         32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
         32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
         32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
         32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
         32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
         32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
         32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
         32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
         32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
         32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
         32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
         32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

      repeat (3) @(negedge clk);
      check("rst_done", {31'b0, done}, 1);
      check("rst_vld", {31'b0, out_valid}, 0);
      check("rst_out", out0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      set_abc();
      do_block(1'b1, 0, DG_ABC, 1, "abc");

      set_empty();
      do_block(1'b1, 5, DG_EMPTY, 1, "empty");

      set_two_a();
      do_block(1'b1, 0, DG_TWO, 0, "two1");
      set_two_b();
      do_block(1'b0, 3, DG_TWO, 1, "two2");

      set_two_a();
      do_block(1'b1, 0, DG_TWO, 0, "mis1");
      set_two_b();
      do_block(1'b1, 0, DG_TWO, 2, "mis2");

      set_abc();
      partial(1'b1, 20, "rst20");
      do_block(1'b1, 0, DG_ABC, 1, "restart");

      partial(1'b0, 30, "pre_rst");
      rst_n = 1'b0;
      #1;
      check("mid_done", {31'b0, done}, 1);
      check("mid_vld", {31'b0, out_valid}, 0);
      check("mid_out", out0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_block(1'b0, 0, DG_ABC, 1, "after_rst");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
